// File: rtl/omi_phy_lane_model.sv
// Loopback model of an OMI PHY lane group: per-lane programmable skew delay line,
// bit-slip alignment tracking with holdoff, and single-cycle bit-error injection.
module omi_phy_lane_model #(
    parameter int  LANES    = 8,
    parameter int  PHY_BITS = 8,
    parameter int  MAX_SKEW = 7,
    parameter int  SLIP_POS = 66,
    parameter int  HOLDOFF  = 32,
    localparam int SW       = (MAX_SKEW > 0) ? $clog2(MAX_SKEW + 1) : 1,
    localparam int PW       = (SLIP_POS > 1) ? $clog2(SLIP_POS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          tx_valid,
    input  logic [2*LANES-1:0]        tx_header,
    input  logic [PHY_BITS*LANES-1:0] tx_data,
    output logic [LANES-1:0]          rx_valid,
    output logic [2*LANES-1:0]        rx_header,
    output logic [PHY_BITS*LANES-1:0] rx_data,
    input  logic [LANES-1:0]          rx_slip,
    input  logic [LANES-1:0]          err_inj,
    input  logic                      cfg_we,
    input  logic [3:0]                cfg_lane,
    input  logic [SW-1:0]             cfg_skew,
    input  logic [PW-1:0]             cfg_target,
    output logic [LANES-1:0]          lane_aligned,
    output logic                      all_aligned
);

    localparam int DEPTH = MAX_SKEW + 1;
    localparam int HW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    function automatic logic [SW-1:0] sat_skew(input logic [31:0] v);
        if (v > 32'(MAX_SKEW))
            return SW'(MAX_SKEW);
        return SW'(v);
    endfunction

    function automatic logic [PW-1:0] sat_target(input logic [31:0] v);
        if (v >= 32'(SLIP_POS))
            return PW'(SLIP_POS - 1);
        return PW'(v);
    endfunction

    logic cfg_ok;
    assign cfg_ok = cfg_we && (32'(cfg_lane) < 32'(LANES));

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic                dly_vld_p0  [DEPTH];
        logic [1:0]          dly_hdr_p0  [DEPTH];
        logic [PHY_BITS-1:0] dly_data_p0 [DEPTH];
        logic [SW-1:0]       skew;
        logic [PW-1:0]       target;
        logic [PW-1:0]       pos;
        logic [HW-1:0]       holdoff;
        logic                cfg_sel;
        logic                aligned;
        logic [PHY_BITS-1:0] tx_word;

        assign cfg_sel = cfg_ok && (cfg_lane == 4'(l));
        assign tx_word = tx_data[l*PHY_BITS +: PHY_BITS] ^ PHY_BITS'(err_inj[l]);

        // tx sample -> delay line; entry 0 holds the word sampled on the last edge
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    dly_vld_p0[i]  <= 1'b0;
                    dly_hdr_p0[i]  <= 2'b00;
                    dly_data_p0[i] <= '0;
                end
            end else begin
                dly_vld_p0[0]  <= tx_valid[l];
                dly_hdr_p0[0]  <= tx_header[2*l +: 2];
                dly_data_p0[0] <= tx_word;
                for (int i = 1; i < DEPTH; i++) begin
                    dly_vld_p0[i]  <= dly_vld_p0[i-1];
                    dly_hdr_p0[i]  <= dly_hdr_p0[i-1];
                    dly_data_p0[i] <= dly_data_p0[i-1];
                end
            end
        end

        // A config write re-arms the lane and wins over a same-cycle slip
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skew    <= '0;
                target  <= '0;
                pos     <= '0;
                holdoff <= '0;
            end else if (cfg_sel) begin
                skew    <= sat_skew(32'(cfg_skew));
                target  <= sat_target(32'(cfg_target));
                pos     <= '0;
                holdoff <= '0;
            end else if (rx_slip[l] && (holdoff == '0)) begin
                pos     <= (pos == PW'(SLIP_POS - 1)) ? '0 : pos + 1'b1;
                holdoff <= HW'(HOLDOFF);
            end else if (holdoff != '0) begin
                holdoff <= holdoff - 1'b1;
            end
        end

        assign aligned                           = (pos == target);
        assign lane_aligned[l]                   = aligned;
        assign rx_valid[l]                       = dly_vld_p0[skew];
        assign rx_header[2*l +: 2]               = aligned ? dly_hdr_p0[skew] : 2'b00;
        assign rx_data[l*PHY_BITS +: PHY_BITS]   = aligned ? dly_data_p0[skew] : ~dly_data_p0[skew];
    end

    // lane status -> registered group status
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            all_aligned <= 1'b0;
        else
            all_aligned <= &lane_aligned;
    end

endmodule

// File: tb/tb_omi_phy_lane_model.sv
// Scoreboard bench for omi_phy_lane_model: directed words push expected
// {header, data, arrival cycle} per lane; a negedge monitor pops and compares.
module tb_omi_phy_lane_model;

    localparam int LANES    = 8;
    localparam int PHY_BITS = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [LANES-1:0]          tx_valid = '0;
    logic [2*LANES-1:0]        tx_header = '0;
    logic [PHY_BITS*LANES-1:0] tx_data = '0;
    logic [LANES-1:0]          rx_valid;
    logic [2*LANES-1:0]        rx_header;
    logic [PHY_BITS*LANES-1:0] rx_data;
    logic [LANES-1:0]          rx_slip = '0;
    logic [LANES-1:0]          err_inj = '0;
    logic                      cfg_we = 1'b0;
    logic [3:0]                cfg_lane = '0;
    logic [2:0]                cfg_skew = '0;
    logic [6:0]                cfg_target = '0;
    logic [LANES-1:0]          lane_aligned;
    logic                      all_aligned;

    omi_phy_lane_model dut (
        .clk          (clk),
        .rst          (rst),
        .tx_valid     (tx_valid),
        .tx_header    (tx_header),
        .tx_data      (tx_data),
        .rx_valid     (rx_valid),
        .rx_header    (rx_header),
        .rx_data      (rx_data),
        .rx_slip      (rx_slip),
        .err_inj      (err_inj),
        .cfg_we       (cfg_we),
        .cfg_lane     (cfg_lane),
        .cfg_skew     (cfg_skew),
        .cfg_target   (cfg_target),
        .lane_aligned (lane_aligned),
        .all_aligned  (all_aligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  hdr;
        logic [7:0]  data;
        logic [31:0] at;
    } exp_t;

    exp_t sbq [LANES][$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic put(int l, logic [1:0] h, logic [7:0] d,
                       logic [1:0] eh, logic [7:0] ed, int skew);
        exp_t e;
        tx_valid[l]          = 1'b1;
        tx_header[2*l +: 2]  = h;
        tx_data[8*l +: 8]    = d;
        e.hdr  = eh;
        e.data = ed;
        e.at   = 32'(cyc + 1 + skew);
        sbq[l].push_back(e);
    endtask

    task automatic cfg(logic [3:0] lane, logic [2:0] skew, logic [6:0] tgt);
        cfg_we     = 1'b1;
        cfg_lane   = lane;
        cfg_skew   = skew;
        cfg_target = tgt;
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            tx_valid = '0;
            err_inj  = '0;
            rx_slip  = '0;
            cfg_we   = 1'b0;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int l = 0; l < LANES; l++) begin
            if (rx_valid[l]) begin
                checks++;
                if (sbq[l].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word lane=%0d actual=%0h/%0h cycle=%0d required=none",
                             l, rx_header[2*l +: 2], rx_data[8*l +: 8], cyc);
                end else begin
                    e = sbq[l].pop_front();
                    if ({rx_header[2*l +: 2], rx_data[8*l +: 8]} !== {e.hdr, e.data} ||
                        32'(cyc) !== e.at) begin
                        failures++;
                        $display("FAIL rx_word lane=%0d actual=%0h/%0h@%0d required=%0h/%0h@%0d",
                                 l, rx_header[2*l +: 2], rx_data[8*l +: 8], cyc, e.hdr, e.data, e.at);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        #1 rst = 1'b1;
        tick(3);
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_rx_header", 32'(rx_header), 0);
        check("reset_rx_data", rx_data[31:0] | rx_data[63:32], 0);
        check("reset_lane_aligned", 32'(lane_aligned), 32'hFF);
        check("reset_all_aligned", 32'(all_aligned), 0);
        rst = 1'b0;
        check("all_aligned_before_edge", 32'(all_aligned), 0);
        tick;
        check("all_aligned_after_reset", 32'(all_aligned), 1);

        // skew 0 passthrough on lane 3
        put(3, 2'b01, 8'hA5, 2'b01, 8'hA5, 0);
        tick;
        tick(3);

        // lane 2 skew 5 against lane 0 skew 0
        cfg(4'd2, 3'd5, 7'd0);
        tick;
        for (int i = 0; i < 4; i++) begin
            put(0, 2'b10, 8'(8'h10 + i), 2'b10, 8'(8'h10 + i), 0);
            put(2, 2'b10, 8'(8'h20 + i), 2'b10, 8'(8'h20 + i), 5);
            tick;
        end
        tick(8);

        // single-cycle error inject on lane 0
        err_inj[0] = 1'b1;
        put(0, 2'b10, 8'h00, 2'b10, 8'h01, 0);
        tick;
        put(0, 2'b10, 8'h00, 2'b10, 8'h00, 0);
        tick;
        tick(2);

        // out-of-range lane write must not alias onto lane 0
        cfg(4'd8, 3'd4, 7'd5);
        tick;
        check("cfg_lane_oob_ignored", 32'(lane_aligned), 32'hFF);
        put(0, 2'b01, 8'h77, 2'b01, 8'h77, 0);
        tick;
        tick(2);

        // slip holdoff: lane 1 target 3, lane 4 target 2
        cfg(4'd1, 3'd0, 7'd3);
        tick;
        cfg(4'd4, 3'd0, 7'd2);
        tick;
        check("misaligned_lanes", 32'(lane_aligned), 32'hED);
        for (int c = 0; c <= 80; c++) begin
            if (c == 0 || c == 10 || c == 40 || c == 80) rx_slip[1] = 1'b1;
            if (c == 0 || c == 10 || c == 32 || c == 33) rx_slip[4] = 1'b1;
            if (c == 79) put(1, 2'b01, 8'h5A, 2'b00, 8'hA5, 0);
            if (c == 80) put(1, 2'b01, 8'h5A, 2'b01, 8'h5A, 0);
            tick;
            if (c == 32) check("slip_in_holdoff_dropped", 32'(lane_aligned[4]), 0);
            if (c == 33) check("slip_after_holdoff", 32'(lane_aligned[4]), 1);
            if (c == 79) check("lane1_before_slip80", 32'(lane_aligned[1]), 0);
            if (c == 80) begin
                check("lane1_aligned_after_slip80", 32'(lane_aligned[1]), 1);
                check("all_aligned_lags", 32'(all_aligned), 0);
            end
        end
        tick;
        check("all_aligned_follows", 32'(all_aligned), 1);
        tick(2);

        // config write beats same-cycle slip and clears holdoff
        cfg(4'd6, 3'd0, 7'd1);
        rx_slip[6] = 1'b1;
        tick;
        check("cfg_beats_slip", 32'(lane_aligned[6]), 0);
        rx_slip[6] = 1'b1;
        tick;
        check("slip_after_cfg", 32'(lane_aligned[6]), 1);

        // target clamp (127 -> 65) and position wrap
        cfg(4'd5, 3'd0, 7'd127);
        tick;
        check("lane5_start_misaligned", 32'(lane_aligned[5]), 0);
        for (int k = 1; k <= 66; k++) begin
            rx_slip[5] = 1'b1;
            tick;
            if (k == 64) check("lane5_slip64", 32'(lane_aligned[5]), 0);
            if (k == 65) check("lane5_slip65_aligned", 32'(lane_aligned[5]), 1);
            if (k == 66) check("lane5_slip66_wrapped", 32'(lane_aligned[5]), 0);
            tick(39);
        end

        // reset with words in flight on a skew-7 lane
        cfg(4'd7, 3'd7, 7'd0);
        tick;
        for (int i = 0; i < 3; i++) begin
            tx_valid[7]    = 1'b1;
            tx_header[15:14] = 2'b11;
            tx_data[63:56] = 8'(8'hE0 + i);
            tick;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_rx_data", rx_data[31:0] | rx_data[63:32], 0);
        check("midrst_rx_valid", 32'(rx_valid), 0);
        check("midrst_lane_aligned", 32'(lane_aligned), 32'hFF);
        check("midrst_all_aligned", 32'(all_aligned), 0);
        tick(2);
        rst = 1'b0;
        tick;
        check("all_aligned_after_midrst", 32'(all_aligned), 1);
        tick(12);
        put(7, 2'b01, 8'h3C, 2'b01, 8'h3C, 0);
        tick;
        tick(3);

        for (int l = 0; l < LANES; l++)
            check("scoreboard_drained", 32'(sbq[l].size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/omi_phy_lane_model.md
OMI_PHY_LANE_MODEL -- requirements
Module: omi_phy_lane_model

Interface
REQ-001 SHALL have parameter LANES, default 8: lane count, 1..16.
REQ-002 SHALL have parameter PHY_BITS, default 8: data bits per lane per cycle.
REQ-003 SHALL have parameter MAX_SKEW, default 7: maximum extra per-lane delay in cycles. SW = clog2(MAX_SKEW+1).
REQ-004 SHALL have parameter SLIP_POS, default 66: number of slip positions per lane. PW = clog2(SLIP_POS).
REQ-005 SHALL have parameter HOLDOFF, default 32: cycles during which further slips are ignored after an accepted slip.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have ports tx_valid (in, LANES), tx_header (in, 2*LANES) and tx_data (in, PHY_BITS*LANES): host transmit; lane l occupies slice l.
REQ-009 SHALL have ports rx_valid (out, LANES), rx_header (out, 2*LANES) and rx_data (out, PHY_BITS*LANES): looped-back receive toward the host.
REQ-010 SHALL have port rx_slip, input, LANES: per-lane slip request from the host.
REQ-011 SHALL have port err_inj, input, LANES: per-lane single-cycle bit-error inject.
REQ-012 SHALL have ports cfg_we (in, 1), cfg_lane (in, 4), cfg_skew (in, SW) and cfg_target (in, PW): configuration write.
REQ-013 SHALL have ports lane_aligned (out, LANES) and all_aligned (out, 1): alignment status.

Function
REQ-014 SHALL keep, per lane, a delay line of MAX_SKEW+1 entries of {valid, header, data}, shifted every cycle.
REQ-015 SHALL present lane l's rx outputs exactly 1+skew[l] cycles after the tx inputs are sampled.
REQ-016 SHALL, when skew changes, keep the delay-line contents and switch the output tap on the cycle after the write, so stale or duplicated words are expected.
REQ-017 SHALL, on err_inj[l], XOR bit 0 of that cycle's tx data for lane l before storage; all other bits and the header are unaffected.
REQ-018 SHALL keep, per lane, slip position pos[l] (0..SLIP_POS-1) and target[l]; lane_aligned[l] = (pos[l] == target[l]).
REQ-019 SHALL accept rx_slip[l] only when holdoff[l] == 0; on acceptance pos[l] increments, wrapping SLIP_POS-1 to 0, and holdoff[l] loads HOLDOFF.
REQ-020 SHALL decrement holdoff[l] each cycle while it is nonzero; a slip arriving while it is nonzero is dropped without effect.
REQ-021 SHALL update lane_aligned on the cycle after an accepted slip.
REQ-022 SHALL, while lane l is misaligned, drive rx_header = 2'b00 and rx_data = inverted delayed data; rx_valid passes through unchanged.
REQ-023 SHALL, while lane l is aligned, pass the delayed header and data unmodified.
REQ-024 SHALL, on cfg_we with cfg_lane < LANES, load skew and target for that lane, clear pos to 0 and clear holdoff.
REQ-025 SHALL ignore cfg_we when cfg_lane >= LANES.
REQ-026 SHALL apply cfg_we over rx_slip on the same lane in the same cycle; the slip is discarded.
REQ-027 SHALL clamp a cfg_skew above MAX_SKEW to MAX_SKEW.
REQ-028 SHALL clamp a cfg_target >= SLIP_POS to SLIP_POS-1.
REQ-029 SHALL drive all_aligned = AND of lane_aligned, registered with one cycle of latency.

Reset
REQ-030 SHALL, on rst assertion and asynchronously, clear all delay lines, skew, target, pos and holdoff to 0.
REQ-031 SHALL, while in reset, drive rx_valid, rx_header and rx_data to 0, lane_aligned to all ones and all_aligned to 0.
REQ-032 SHALL, after reset deasserts, drive all_aligned to 1 one cycle later.
REQ-033 SHALL, on reset asserted mid-operation, drop all in-flight words without emitting them.

Verification
REQ-034 SHALL cover: skew 0 on all lanes, tx_data lane3 = 0xA5 with header 01 -> rx lane3 = 0xA5, header 01, one cycle later.
REQ-035 SHALL cover: cfg lane2 skew 5, then a tx word sequence -> lane2 output lags lane0 by exactly 5 cycles.
REQ-036 SHALL cover: cfg lane1 target 3, slips at cycles 0, 10, 40, 80 -> slip at 10 dropped, pos 3 reached after slip at 80, lane_aligned[1] rises the next cycle, header 00 and data inverted before that.
REQ-037 SHALL cover: target 65 with 66 slips spaced 40 cycles -> alignment reached after slip 65, then lost after slip 66 (pos wraps to 0).
REQ-038 SHALL cover: err_inj[0] with tx 0x00 -> exactly one rx word 0x01 on lane0.
REQ-039 SHALL cover: rst pulse with skew 7 and data in flight -> rx_data 0 immediately and no old words emitted afterward.
